// File: rtl/seq_pkg.sv
// Shared constants for the serial feeder and the downstream sequence detector.
package seq_pkg;

    // Feeder state encoding.
    localparam logic FEED_IDLE  = 1'b0;
    localparam logic FEED_SHIFT = 1'b1;

    typedef enum logic {
        FeedIdle  = FEED_IDLE,
        FeedShift = FEED_SHIFT
    } feed_state_e;

    // Bit pattern the detector looks for in the serial stream.
    localparam logic [4:0] DET_PATTERN = 5'b10010;

endpackage

// File: rtl/serial_bit_feeder.sv
// Parallel-to-serial feeder: takes WIDTH-bit words over valid/ready and drives
// one bit per clock on j, reloading on the last bit so words stream gap-free.
module serial_bit_feeder
    import seq_pkg::*;
#(
    parameter int unsigned WIDTH     = 8,
    parameter bit          MSB_FIRST = 1'b1,
    parameter logic        IDLE_BIT  = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             j,
    output logic             j_valid,
    output logic             last,
    output logic             busy
);

    localparam int unsigned CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);
    localparam logic [CW-1:0] PEN_CNT  = CW'(WIDTH - 2);

    feed_state_e      state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic             j_q, j_d;
    logic             j_valid_q, j_valid_d;
    logic             last_q, last_d;
    logic             accept;

    // The bit nearest the output end of a word, and the word advanced one bit.
    function automatic logic head_bit(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? w[WIDTH-1] : w[0];
    endfunction

    function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? (w << 1) : (w >> 1);
    endfunction

    // Ready while idle or while the final bit of the current word is on j.
    always_comb begin
        din_ready = (state_q == FeedIdle) || (cnt_q == LAST_CNT);
        accept    = din_valid && din_ready;
    end

    // Next-state logic for the FSM, counter, shift register and j outputs.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        sr_d      = sr_q;
        j_d       = j_q;
        j_valid_d = j_valid_q;
        last_d    = last_q;

        if (accept) begin
            // First bit goes straight to j; the rest wait in the shift register.
            state_d   = FeedShift;
            cnt_d     = '0;
            sr_d      = advance(din);
            j_d       = head_bit(din);
            j_valid_d = 1'b1;
            last_d    = 1'b0;
        end else if (state_q == FeedShift) begin
            if (cnt_q != LAST_CNT) begin
                cnt_d  = cnt_q + 1'b1;
                j_d    = head_bit(sr_q);
                sr_d   = advance(sr_q);
                last_d = (cnt_q == PEN_CNT);
            end else begin
                state_d   = FeedIdle;
                cnt_d     = '0;
                j_d       = IDLE_BIT;
                j_valid_d = 1'b0;
                last_d    = 1'b0;
            end
        end else begin
            j_d       = IDLE_BIT;
            j_valid_d = 1'b0;
            last_d    = 1'b0;
        end
    end

    // State and output registers with asynchronous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= FeedIdle;
            cnt_q     <= '0;
            sr_q      <= '0;
            j_q       <= IDLE_BIT;
            j_valid_q <= 1'b0;
            last_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            sr_q      <= sr_d;
            j_q       <= j_d;
            j_valid_q <= j_valid_d;
            last_q    <= last_d;
        end
    end

    assign j       = j_q;
    assign j_valid = j_valid_q;
    assign last    = last_q;
    assign busy    = (state_q == FeedShift);

endmodule

// File: tb/tb_serial_bit_feeder.sv
// Bench for serial_bit_feeder: a queue-based stream model checked every cycle,
// plus literal expectations for bit order, word counts and pattern hits.
module tb_serial_bit_feeder;
    import seq_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;

    // Instance A: WIDTH=8, MSB first, idle 0.
    logic [7:0] din_a = '0;
    logic       dv_a  = 1'b0;
    logic       rdy_a, j_a, jv_a, last_a, busy_a;
    // Instance B: WIDTH=4, LSB first, idle 1.
    logic [3:0] din_b = '0;
    logic       dv_b  = 1'b0;
    logic       rdy_b, j_b, jv_b, last_b, busy_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    serial_bit_feeder #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) u_a (
        .clk(clk), .rst(rst), .din(din_a), .din_valid(dv_a), .din_ready(rdy_a),
        .j(j_a), .j_valid(jv_a), .last(last_a), .busy(busy_a)
    );

    serial_bit_feeder #(.WIDTH(4), .MSB_FIRST(1'b0), .IDLE_BIT(1'b1)) u_b (
        .clk(clk), .rst(rst), .din(din_b), .din_valid(dv_b), .din_ready(rdy_b),
        .j(j_b), .j_valid(jv_b), .last(last_b), .busy(busy_b)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Model: the queue holds the bits still to appear on j, head = current bit.
    // Each edge retires the head; an accept (ready = at most one bit left) appends a word.
    logic qa[$];
    logic qb[$];
    bit   acc_a, acc_b;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            qa.delete();
        end else begin
            acc_a = dv_a && (qa.size() <= 1);
            if (qa.size() > 0) void'(qa.pop_front());
            if (acc_a) for (int i = 0; i < 8; i++) qa.push_back(din_a[7-i]);
        end
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            qb.delete();
        end else begin
            acc_b = dv_b && (qb.size() <= 1);
            if (qb.size() > 0) void'(qb.pop_front());
            if (acc_b) for (int i = 0; i < 4; i++) qb.push_back(din_b[i]);
        end
    end

    // Observed-stream statistics, read as deltas by the directed tests.
    logic [31:0] cap_a = '0, cap_b = '0;
    logic [4:0]  hist_a = '0;
    int nv_a = 0, nl_a = 0, det_a = 0, rb_a = 0, nv_b = 0, one_b = 0;

    // Per-cycle compare away from the active edge.
    always @(negedge clk) begin
        if (!rst) begin
            check("a_j",     {31'b0, j_a},    {31'b0, qa.size() > 0 ? qa[0] : 1'b0});
            check("a_valid", {31'b0, jv_a},   {31'b0, qa.size() > 0});
            check("a_last",  {31'b0, last_a}, {31'b0, qa.size() == 1});
            check("a_busy",  {31'b0, busy_a}, {31'b0, qa.size() > 0});
            check("a_ready", {31'b0, rdy_a},  {31'b0, qa.size() <= 1});
            check("b_j",     {31'b0, j_b},    {31'b0, qb.size() > 0 ? qb[0] : 1'b1});
            check("b_valid", {31'b0, jv_b},   {31'b0, qb.size() > 0});
            check("b_last",  {31'b0, last_b}, {31'b0, qb.size() == 1});
            check("b_busy",  {31'b0, busy_b}, {31'b0, qb.size() > 0});
            check("b_ready", {31'b0, rdy_b},  {31'b0, qb.size() <= 1});
            hist_a = {hist_a[3:0], j_a};
            if (hist_a == DET_PATTERN) det_a++;
            if (jv_a) begin cap_a = {cap_a[30:0], j_a}; nv_a++; end
            if (last_a) nl_a++;
            if (rdy_a && busy_a) rb_a++;
            if (jv_b) begin cap_b = {cap_b[30:0], j_b}; nv_b++; end
            if (!jv_b && j_b) one_b++;
        end
    end

    // Present a word on A and return #1 after the edge that accepts it.
    task automatic send_a(input logic [7:0] w);
        bit r;
        int n;
        din_a = w;
        dv_a  = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            r = rdy_a;
            @(posedge clk);
            n++;
        end while (!r && n < 64);
        if (!r) check("a_accept_timeout", 32'd0, 32'd1);
        #1;
    endtask

    task automatic send_b(input logic [3:0] w);
        bit r;
        int n;
        din_b = w;
        dv_b  = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            r = rdy_b;
            @(posedge clk);
            n++;
        end while (!r && n < 64);
        if (!r) check("b_accept_timeout", 32'd0, 32'd1);
        #1;
    endtask

    task automatic idle(input int n);
        dv_a = 1'b0;
        dv_b = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    int b_nv, b_nl, b_det, b_rb, b_one;

    initial begin
        // Reset values.
        #12;
        check("rst_a_j",     {31'b0, j_a},    32'd0);
        check("rst_a_valid", {31'b0, jv_a},   32'd0);
        check("rst_a_last",  {31'b0, last_a}, 32'd0);
        check("rst_a_busy",  {31'b0, busy_a}, 32'd0);
        check("rst_b_j",     {31'b0, j_b},    32'd1);
        @(posedge clk); #1;
        rst = 1'b0;

        // Idle fill of 1 on B for 20 cycles, ready held high.
        b_one = one_b;
        idle(20);
        check("t6_idle_ones", one_b - b_one, 32'd20);

        // Single word 10010010, MSB first; pattern hits twice (overlapping).
        b_nv = nv_a; b_nl = nl_a; b_det = det_a;
        send_a(8'b1001_0010);
        idle(12);
        check("t1_bits",   {24'b0, cap_a[7:0]}, 32'h92);
        check("t1_nvalid", nv_a - b_nv,   32'd8);
        check("t1_nlast",  nl_a - b_nl,   32'd1);
        check("t1_det",    det_a - b_det, 32'd2);

        // Back-to-back A5, 3C with no idle bit between.
        b_nv = nv_a; b_det = det_a; b_rb = rb_a;
        send_a(8'hA5);
        send_a(8'h3C);
        idle(12);
        check("t2_bits",   {16'b0, cap_a[15:0]}, 32'hA53C);
        check("t2_nvalid", nv_a - b_nv,   32'd16);
        check("t2_rdy",    rb_a - b_rb,   32'd2);
        check("t2_det",    det_a - b_det, 32'd1);

        // Pattern straddling a word boundary.
        b_det = det_a;
        send_a(8'b0000_0100);
        send_a(8'b1000_0000);
        idle(12);
        check("t3_bits", {16'b0, cap_a[15:0]}, 32'h0480);
        check("t3_det",  det_a - b_det, 32'd1);

        // Asynchronous reset after three bits of FF.
        send_a(8'hFF);
        dv_a = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("t4_j",     {31'b0, j_a},    32'd0);
        check("t4_valid", {31'b0, jv_a},   32'd0);
        check("t4_busy",  {31'b0, busy_a}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        b_nv = nv_a;
        send_a(8'hC4);
        idle(12);
        check("t4_bits",   {24'b0, cap_a[7:0]}, 32'hC4);
        check("t4_nvalid", nv_a - b_nv, 32'd8);

        // LSB first, WIDTH 4; a valid pulse mid-word is ignored.
        b_nv = nv_b;
        send_b(4'b0110);
        dv_b = 1'b0;
        @(posedge clk); #1;
        din_b = 4'hF;
        dv_b  = 1'b1;
        @(posedge clk); #1;
        idle(8);
        check("t5_bits",   {28'b0, cap_b[3:0]}, 32'h6);
        check("t5_nvalid", nv_b - b_nv, 32'd4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
